// File: rtl/mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : Mem_ift
// Brief    : Split read/write memory interface. Each channel has a request
//            handshake followed by a reply handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface Mem_ift #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int MASK_W = DATA_W / 8
);
    // read channel
    logic              r_request_valid;
    logic              r_request_ready;
    logic [ADDR_W-1:0] r_request_addr;
    logic              r_reply_valid;
    logic              r_reply_ready;
    logic [DATA_W-1:0] r_reply_rdata;

    // write channel
    logic              w_request_valid;
    logic              w_request_ready;
    logic [ADDR_W-1:0] w_request_addr;
    logic [DATA_W-1:0] w_request_data;
    logic [MASK_W-1:0] w_request_mask;
    logic              w_reply_valid;
    logic              w_reply_ready;

    modport Master (
        output r_request_valid, r_request_addr, r_reply_ready,
        output w_request_valid, w_request_addr, w_request_data, w_request_mask, w_reply_ready,
        input  r_request_ready, r_reply_valid, r_reply_rdata,
        input  w_request_ready, w_reply_valid
    );

    modport Slave (
        input  r_request_valid, r_request_addr, r_reply_ready,
        input  w_request_valid, w_request_addr, w_request_data, w_request_mask, w_reply_ready,
        output r_request_ready, r_reply_valid, r_reply_rdata,
        output w_request_ready, w_reply_valid
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter
// Brief    : Shares one memory port between instruction fetch and data
//            requesters; data has priority, fetch is protected from starvation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    Mem_ift.Slave      imem_ift,
    Mem_ift.Slave      dmem_ift,
    Mem_ift.Master     mem_ift,
    output logic [1:0] grant,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IR_REQ = 3'd1;
    localparam logic [2:0] S_IR_REP = 3'd2;
    localparam logic [2:0] S_DR_REQ = 3'd3;
    localparam logic [2:0] S_DR_REP = 3'd4;
    localparam logic [2:0] S_DW_REQ = 3'd5;
    localparam logic [2:0] S_DW_REP = 3'd6;

    localparam int            c_CNT_W    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);
    localparam bit            c_FORCE_EN = (STARVE_LIMIT != 0);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic [c_CNT_W-1:0] w_starve_nxt;
    logic               w_force_imem;

    assign w_force_imem = imem_ift.r_request_valid && c_FORCE_EN && (r_starve_cnt == c_LIMIT);

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_force_imem)                  w_state_nxt = S_IR_REQ;
                else if (dmem_ift.r_request_valid) w_state_nxt = S_DR_REQ;
                else if (dmem_ift.w_request_valid) w_state_nxt = S_DW_REQ;
                else if (imem_ift.r_request_valid) w_state_nxt = S_IR_REQ;

                // Only dmem wins taken while fetch is waiting count toward starvation.
                if (!imem_ift.r_request_valid || w_state_nxt == S_IR_REQ)
                    w_starve_nxt = '0;
                else if (r_starve_cnt != c_LIMIT)
                    w_starve_nxt = r_starve_cnt + 1'b1;
            end
            S_IR_REQ: begin
                if (!imem_ift.r_request_valid)    w_state_nxt = S_IDLE;
                else if (mem_ift.r_request_ready) w_state_nxt = S_IR_REP;
            end
            S_IR_REP: begin
                if (mem_ift.r_reply_valid && imem_ift.r_reply_ready) w_state_nxt = S_IDLE;
            end
            S_DR_REQ: begin
                if (!dmem_ift.r_request_valid)    w_state_nxt = S_IDLE;
                else if (mem_ift.r_request_ready) w_state_nxt = S_DR_REP;
            end
            S_DR_REP: begin
                if (mem_ift.r_reply_valid && dmem_ift.r_reply_ready) w_state_nxt = S_IDLE;
            end
            S_DW_REQ: begin
                if (!dmem_ift.w_request_valid)    w_state_nxt = S_IDLE;
                else if (mem_ift.w_request_ready) w_state_nxt = S_DW_REP;
            end
            S_DW_REP: begin
                if (mem_ift.w_reply_valid && dmem_ift.w_reply_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        // downstream request side
        mem_ift.r_request_valid = ((r_state == S_IR_REQ) && imem_ift.r_request_valid)
                               || ((r_state == S_DR_REQ) && dmem_ift.r_request_valid);
        mem_ift.r_request_addr  = (r_state == S_IR_REQ) ? imem_ift.r_request_addr
                                                        : dmem_ift.r_request_addr;
        mem_ift.w_request_valid = (r_state == S_DW_REQ) && dmem_ift.w_request_valid;
        mem_ift.w_request_addr  = dmem_ift.w_request_addr;
        mem_ift.w_request_data  = dmem_ift.w_request_data;
        mem_ift.w_request_mask  = dmem_ift.w_request_mask;
        mem_ift.r_reply_ready   = ((r_state == S_IR_REP) && imem_ift.r_reply_ready)
                               || ((r_state == S_DR_REP) && dmem_ift.r_reply_ready);
        mem_ift.w_reply_ready   = (r_state == S_DW_REP) && dmem_ift.w_reply_ready;

        // fetch requester: read only, write channel held off
        imem_ift.r_request_ready = (r_state == S_IR_REQ) && mem_ift.r_request_ready;
        imem_ift.r_reply_valid   = (r_state == S_IR_REP) && mem_ift.r_reply_valid;
        imem_ift.r_reply_rdata   = mem_ift.r_reply_rdata;
        imem_ift.w_request_ready = 1'b0;
        imem_ift.w_reply_valid   = 1'b0;

        // data requester
        dmem_ift.r_request_ready = (r_state == S_DR_REQ) && mem_ift.r_request_ready;
        dmem_ift.r_reply_valid   = (r_state == S_DR_REP) && mem_ift.r_reply_valid;
        dmem_ift.r_reply_rdata   = mem_ift.r_reply_rdata;
        dmem_ift.w_request_ready = (r_state == S_DW_REQ) && mem_ift.w_request_ready;
        dmem_ift.w_reply_valid   = (r_state == S_DW_REP) && mem_ift.w_reply_valid;
    end

    always_comb begin
        grant = 2'd0;
        case (r_state)
            S_IR_REQ, S_IR_REP: grant = 2'd1;
            S_DR_REQ, S_DR_REP: grant = 2'd2;
            S_DW_REQ, S_DW_REP: grant = 2'd3;
            default:            grant = 2'd0;
        endcase
    end

    assign busy = (r_state != S_IDLE);

    // The fetch write channel is never serviced.
    logic w_unused_imem_w;
    assign w_unused_imem_w = ^{imem_ift.w_request_valid, imem_ift.w_request_addr,
                               imem_ift.w_request_data, imem_ift.w_request_mask,
                               imem_ift.w_reply_ready};

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] grant;
    logic       busy;

    int n_vec;
    int n_miss;

    Mem_ift imem_if ();
    Mem_ift dmem_if ();
    Mem_ift mem_if  ();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .imem_ift (imem_if),
        .dmem_ift (dmem_if),
        .mem_ift  (mem_if),
        .grant    (grant),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_seq [8];

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        imem_if.r_request_valid = 0; imem_if.r_request_addr = '0; imem_if.r_reply_ready = 0;
        imem_if.w_request_valid = 0; imem_if.w_request_addr = '0; imem_if.w_request_data = '0;
        imem_if.w_request_mask  = '0; imem_if.w_reply_ready = 0;
        dmem_if.r_request_valid = 0; dmem_if.r_request_addr = '0; dmem_if.r_reply_ready = 0;
        dmem_if.w_request_valid = 0; dmem_if.w_request_addr = '0; dmem_if.w_request_data = '0;
        dmem_if.w_request_mask  = '0; dmem_if.w_reply_ready = 0;
        mem_if.r_request_ready = 0; mem_if.r_reply_valid = 0; mem_if.r_reply_rdata = '0;
        mem_if.w_request_ready = 0; mem_if.w_reply_valid = 0;

        repeat (3) tick();
        check_val("rst_grant", 64'(grant), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_mem_rv", 64'(mem_if.r_request_valid), 64'd0);
        check_val("rst_mem_wv", 64'(mem_if.w_request_valid), 64'd0);
        check_val("rst_imem_rrdy", 64'(imem_if.r_request_ready), 64'd0);
        rst = 1'b0;
        tick();

        // single fetch, memory accepts one cycle late
        imem_if.r_request_valid = 1; imem_if.r_request_addr = 32'h100; imem_if.r_reply_ready = 1;
        #1;
        check_val("t1_idle_mem_rv", 64'(mem_if.r_request_valid), 64'd0);
        tick(); #1;
        check_val("t1_req_grant", 64'(grant), 64'd1);
        check_val("t1_req_busy", 64'(busy), 64'd1);
        check_val("t1_req_mem_rv", 64'(mem_if.r_request_valid), 64'd1);
        check_val("t1_req_addr", 64'(mem_if.r_request_addr), 64'h100);
        check_val("t1_req_rdy0", 64'(imem_if.r_request_ready), 64'd0);
        tick();
        mem_if.r_request_ready = 1; #1;
        check_val("t1_req_rdy1", 64'(imem_if.r_request_ready), 64'd1);
        tick();
        mem_if.r_request_ready = 0; imem_if.r_request_valid = 0;
        mem_if.r_reply_valid = 1; mem_if.r_reply_rdata = 64'h00000013_00000093; #1;
        check_val("t1_rep_grant", 64'(grant), 64'd1);
        check_val("t1_rep_ivalid", 64'(imem_if.r_reply_valid), 64'd1);
        check_val("t1_rep_rdata", imem_if.r_reply_rdata, 64'h00000013_00000093);
        check_val("t1_rep_dvalid", 64'(dmem_if.r_reply_valid), 64'd0);
        check_val("t1_rep_mem_rrdy", 64'(mem_if.r_reply_ready), 64'd1);
        check_val("t1_rep_mem_rv", 64'(mem_if.r_request_valid), 64'd0);
        tick();
        mem_if.r_reply_valid = 0; #1;
        check_val("t1_end_grant", 64'(grant), 64'd0);
        check_val("t1_end_busy", 64'(busy), 64'd0);

        // memory always ready from here on
        mem_if.r_request_ready = 1; mem_if.w_request_ready = 1;
        mem_if.r_reply_valid = 1; mem_if.w_reply_valid = 1;
        mem_if.r_reply_rdata = 64'h1111_2222_3333_4444;
        dmem_if.r_reply_ready = 1; dmem_if.w_reply_ready = 1;

        // simultaneous fetch and data read
        imem_if.r_request_valid = 1; imem_if.r_request_addr = 32'h104;
        dmem_if.r_request_valid = 1; dmem_if.r_request_addr = 32'h300;
        #1;
        check_val("t2_idle_ivalid", 64'(imem_if.r_reply_valid), 64'd0);
        tick(); #1;
        check_val("t2_dreq_grant", 64'(grant), 64'd2);
        check_val("t2_dreq_addr", 64'(mem_if.r_request_addr), 64'h300);
        check_val("t2_dreq_irdy", 64'(imem_if.r_request_ready), 64'd0);
        check_val("t2_dreq_drdy", 64'(dmem_if.r_request_ready), 64'd1);
        tick();
        dmem_if.r_request_valid = 0; #1;
        check_val("t2_drep_grant", 64'(grant), 64'd2);
        check_val("t2_drep_dvalid", 64'(dmem_if.r_reply_valid), 64'd1);
        check_val("t2_drep_ivalid", 64'(imem_if.r_reply_valid), 64'd0);
        check_val("t2_drep_irdy", 64'(imem_if.r_request_ready), 64'd0);
        check_val("t2_drep_rdata", dmem_if.r_reply_rdata, 64'h1111_2222_3333_4444);
        tick(); #1;
        check_val("t2_idle_grant", 64'(grant), 64'd0);
        check_val("t2_idle_irdy", 64'(imem_if.r_request_ready), 64'd0);
        tick(); #1;
        check_val("t2_ireq_grant", 64'(grant), 64'd1);
        check_val("t2_ireq_irdy", 64'(imem_if.r_request_ready), 64'd1);
        check_val("t2_ireq_addr", 64'(mem_if.r_request_addr), 64'h104);
        tick();
        imem_if.r_request_valid = 0; #1;
        check_val("t2_irep_grant", 64'(grant), 64'd1);
        tick(); #1;
        check_val("t2_end_grant", 64'(grant), 64'd0);
        tick();

        // starvation bound: 4 data grants, forced fetch, then data again
        exp_seq[0] = 2'd2; exp_seq[1] = 2'd2; exp_seq[2] = 2'd2; exp_seq[3] = 2'd2;
        exp_seq[4] = 2'd1; exp_seq[5] = 2'd2; exp_seq[6] = 2'd2; exp_seq[7] = 2'd1;
        imem_if.r_request_valid = 1; dmem_if.r_request_valid = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_val($sformatf("t3_idle%0d", i), 64'(grant), 64'd0);
            tick(); #1;
            check_val($sformatf("t3_grant%0d", i), 64'(grant), 64'(exp_seq[i]));
            tick();
            if (i == 6) dmem_if.r_request_valid = 0;
            if (i == 7) imem_if.r_request_valid = 0;
            tick();
        end

        // data write
        dmem_if.w_request_valid = 1; dmem_if.w_request_addr = 32'h208;
        dmem_if.w_request_data = 64'hDEADBEEF; dmem_if.w_request_mask = 8'h0F;
        #1;
        check_val("t4_idle_grant", 64'(grant), 64'd0);
        tick(); #1;
        check_val("t4_req_grant", 64'(grant), 64'd3);
        check_val("t4_req_wv", 64'(mem_if.w_request_valid), 64'd1);
        check_val("t4_req_waddr", 64'(mem_if.w_request_addr), 64'h208);
        check_val("t4_req_wdata", mem_if.w_request_data, 64'hDEADBEEF);
        check_val("t4_req_wmask", 64'(mem_if.w_request_mask), 64'h0F);
        check_val("t4_req_rv", 64'(mem_if.r_request_valid), 64'd0);
        check_val("t4_req_wrdy", 64'(dmem_if.w_request_ready), 64'd1);
        tick();
        dmem_if.w_request_valid = 0; #1;
        check_val("t4_rep_wvalid", 64'(dmem_if.w_reply_valid), 64'd1);
        check_val("t4_rep_mem_wrdy", 64'(mem_if.w_reply_ready), 64'd1);
        check_val("t4_rep_mem_rrdy", 64'(mem_if.r_reply_ready), 64'd0);
        check_val("t4_rep_rvalid", 64'(dmem_if.r_reply_valid), 64'd0);
        tick(); #1;
        check_val("t4_end_grant", 64'(grant), 64'd0);

        // read and write together: read first, then write, each once
        dmem_if.r_request_valid = 1; dmem_if.r_request_addr = 32'h40;
        dmem_if.w_request_valid = 1;
        tick(); #1;
        check_val("t5_r_grant", 64'(grant), 64'd2);
        check_val("t5_r_mem_wv", 64'(mem_if.w_request_valid), 64'd0);
        tick();
        dmem_if.r_request_valid = 0;
        tick(); #1;
        check_val("t5_idle_grant", 64'(grant), 64'd0);
        tick(); #1;
        check_val("t5_w_grant", 64'(grant), 64'd3);
        tick();
        dmem_if.w_request_valid = 0;
        tick(); #1;
        check_val("t5_idle2_grant", 64'(grant), 64'd0);
        tick(); #1;
        check_val("t5_idle3_grant", 64'(grant), 64'd0);

        // requester withdraws before the handshake
        mem_if.r_request_ready = 0;
        dmem_if.r_request_valid = 1;
        tick(); #1;
        check_val("t6_req_grant", 64'(grant), 64'd2);
        check_val("t6_req_drdy", 64'(dmem_if.r_request_ready), 64'd0);
        dmem_if.r_request_valid = 0;
        tick(); #1;
        check_val("t6_abort_grant", 64'(grant), 64'd0);
        check_val("t6_abort_busy", 64'(busy), 64'd0);

        // reset during a data-read reply
        mem_if.r_request_ready = 1; dmem_if.r_reply_ready = 0;
        dmem_if.r_request_valid = 1;
        tick();
        tick();
        dmem_if.r_request_valid = 0; #1;
        check_val("t7_rep_grant", 64'(grant), 64'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; dmem_if.r_reply_ready = 1; #1;
        check_val("t7_rst_grant", 64'(grant), 64'd0);
        check_val("t7_rst_busy", 64'(busy), 64'd0);
        check_val("t7_rst_mem_rv", 64'(mem_if.r_request_valid), 64'd0);
        check_val("t7_rst_mem_rrdy", 64'(mem_if.r_reply_ready), 64'd0);
        check_val("t7_rst_dvalid", 64'(dmem_if.r_reply_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
